// File: rtl/mem_access_stage.sv
// MEM pipeline stage: formats loads/stores and runs a single-outstanding data-bus FSM.
// Optional MISALIGN_TRAP_EN traps misaligned accesses instead of masking the low address bits.
module mem_access_stage (
  input  logic        clk_i,
  input  logic        n_rst,
  input  logic        flush_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_wb_en_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [1:0]  ex_mem_op_i,
  input  logic [2:0]  ex_mem_funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [4:0]  mem_rd_o,
  output logic        mem_wb_en_o,
  output logic [31:0] mem_wb_value_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  state_t      r_state;
  logic        r_kill, r_load, r_uns, r_wb_en, r_req, r_we;
  logic [1:0]  r_size, r_off;
  logic [4:0]  r_rd;
  logic [31:0] r_value, r_addr, r_wdata;
  logic [3:0]  r_be;

  logic        w_is_ld, w_is_st, w_is_mem, w_uns, w_trap, w_issue, w_stall;
  logic [1:0]  w_size, w_off;
  logic [31:0] w_wdata, w_ld_shift, w_ld_fmt;
  logic [3:0]  w_be;

  assign w_is_ld  = (ex_mem_op_i == 2'b01);
  assign w_is_st  = (ex_mem_op_i == 2'b10);
  assign w_is_mem = w_is_ld | w_is_st;

  always_comb begin
    w_uns  = 1'b0;
    w_size = SZ_W;
    case (ex_mem_funct3_i)
      3'b000:  w_size = SZ_B;
      3'b001:  w_size = SZ_H;
      3'b100:  begin w_size = SZ_B; w_uns = 1'b1; end
      3'b101:  begin w_size = SZ_H; w_uns = 1'b1; end
      default: w_size = SZ_W;
    endcase
  end

  // Byte offset with the bits a halfword/word cannot use forced to zero
  assign w_off = (w_size == SZ_B) ? ex_result_i[1:0] :
                 (w_size == SZ_H) ? {ex_result_i[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis  = ((w_size == SZ_H) && ex_result_i[0]) ||
                  ((w_size == SZ_W) && (ex_result_i[1:0] != 2'b00));
  assign w_trap = (r_state == S_IDLE) && ex_valid_i && w_is_mem && !flush_i && w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) && ex_valid_i && w_is_mem && !flush_i && !w_trap;

  always_comb begin
    w_wdata = ex_store_data_i;
    w_be    = 4'b1111;
    case (w_size)
      SZ_B: begin w_wdata = {4{ex_store_data_i[7:0]}};  w_be = 4'b0001 << w_off; end
      SZ_H: begin w_wdata = {2{ex_store_data_i[15:0]}}; w_be = 4'b0011 << w_off; end
      default: ;
    endcase
  end

  assign w_ld_shift = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ld_fmt = w_ld_shift;
    case (r_size)
      SZ_B: w_ld_fmt = {{24{~r_uns & w_ld_shift[7]}},  w_ld_shift[7:0]};
      SZ_H: w_ld_fmt = {{16{~r_uns & w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: ;
    endcase
  end

  // Write-back path: combinational pass-through in IDLE, latched result in DONE, bubble while stalled
  always_comb begin
    w_stall        = 1'b0;
    mem_rd_o       = '0;
    mem_wb_en_o    = 1'b0;
    mem_wb_value_o = '0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_issue;
        if (ex_valid_i && !w_is_mem && !flush_i) begin
          mem_rd_o       = ex_rd_i;
          mem_wb_en_o    = ex_wb_en_i;
          mem_wb_value_o = ex_result_i;
        end
      end
      S_REQ, S_WAIT: w_stall = 1'b1;
      S_DONE: if (!flush_i) begin
        mem_rd_o       = r_rd;
        mem_wb_en_o    = r_wb_en;
        mem_wb_value_o = r_value;
      end
      default: ;
    endcase
  end

  assign stall_o      = w_stall & n_rst;
  assign misalign_o   = w_trap & n_rst;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
      r_load  <= 1'b0;
      r_uns   <= 1'b0;
      r_wb_en <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_rd    <= '0;
      r_value <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_we    <= w_is_st;
          r_addr  <= {ex_result_i[31:2], 2'b00};
          r_wdata <= w_wdata;
          r_be    <= w_be;
          r_rd    <= ex_rd_i;
          r_wb_en <= w_is_ld & ex_wb_en_i;
          r_load  <= w_is_ld;
          r_size  <= w_size;
          r_uns   <= w_uns;
          r_off   <= w_off;
          r_kill  <= 1'b0;
          r_value <= '0;
        end
        S_REQ: if (dmem_gnt_i) begin
          // A granted access is never retracted; a flush here only suppresses write-back
          r_req <= 1'b0;
          r_we  <= 1'b0;
          if (flush_i) r_kill <= 1'b1;
          if (r_load)  r_state <= S_WAIT;
          else         r_state <= flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (flush_i) r_kill <= 1'b1;
          if (dmem_rvalid_i) begin
            if (r_kill || flush_i) r_state <= S_IDLE;
            else begin
              r_value <= w_ld_fmt;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; write-backs are checked against a scoreboard queue.
module tb_mem_access_stage;
  logic        clk_i = 1'b0, n_rst = 1'b0, flush_i = 1'b0, ex_valid_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_wb_en_i = 1'b0;
  logic [31:0] ex_result_i = '0, ex_store_data_i = '0;
  logic [1:0]  ex_mem_op_i = '0;
  logic [2:0]  ex_mem_funct3_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o, misalign_o;
  logic [4:0]  mem_rd_o;
  logic        mem_wb_en_o;
  logic [31:0] mem_wb_value_o;

  mem_access_stage dut (
    .clk_i(clk_i), .n_rst(n_rst), .flush_i(flush_i), .ex_valid_i(ex_valid_i),
    .ex_rd_i(ex_rd_i), .ex_wb_en_i(ex_wb_en_i), .ex_result_i(ex_result_i),
    .ex_store_data_i(ex_store_data_i), .ex_mem_op_i(ex_mem_op_i),
    .ex_mem_funct3_i(ex_mem_funct3_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o), .mem_rd_o(mem_rd_o),
    .mem_wb_en_o(mem_wb_en_o), .mem_wb_value_o(mem_wb_value_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  typedef struct packed { logic [4:0] rd; logic [31:0] val; } wb_t;
  wb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write-back the DUT emits must match the oldest expected entry
  always @(negedge clk_i) begin
    wb_t e;
    #2;
    if (n_rst === 1'b1 && mem_wb_en_o === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_wb: rd %0d value %h with empty scoreboard", mem_rd_o, mem_wb_value_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_rd", {27'd0, mem_rd_o}, {27'd0, e.rd});
        chk("wb_val", mem_wb_value_o, e.val);
      end
    end
  end

  task automatic set_ex(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input logic wb);
    ex_valid_i = v; ex_mem_op_i = op; ex_mem_funct3_i = f3; ex_result_i = a;
    ex_store_data_i = sd; ex_rd_i = rd; ex_wb_en_i = wb;
  endtask

  task automatic alu(input logic [4:0] rd, input logic wb, input logic [31:0] res, input logic [1:0] op);
    wb_t e;
    @(negedge clk_i);
    set_ex(1'b1, op, 3'b010, res, 32'h0, rd, wb);
    if (wb) begin e.rd = rd; e.val = res; sb.push_back(e); end
    #1;
    chk("alu_stall", {31'd0, stall_o}, 32'd0);
    chk("alu_wb_en", {31'd0, mem_wb_en_o}, {31'd0, wb});
    chk("alu_value", mem_wb_value_o, res);
  endtask

  // Full load/store transaction with grant after gw wait cycles and rvalid in the first WAIT cycle
  task automatic mem(input string nm, input logic [1:0] op, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                     input int gw, input logic [31:0] rdata, input logic [3:0] xbe,
                     input logic [31:0] xwd, input logic [31:0] xval);
    logic ld;
    logic [31:0] xaddr;
    wb_t e;
    ld = (op == 2'b01);
    xaddr = {a[31:2], 2'b00};
    @(negedge clk_i);
    set_ex(1'b1, op, f3, a, sd, rd, 1'b1);
    if (ld) begin e.rd = rd; e.val = xval; sb.push_back(e); end
    #1;
    chk({nm, "_issue_stall"}, {31'd0, stall_o}, 32'd1);
    chk({nm, "_issue_wb"}, {31'd0, mem_wb_en_o}, 32'd0);
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk_i);
      dmem_gnt_i = (i == gw);
      #1;
      chk({nm, "_req"}, {31'd0, dmem_req_o}, 32'd1);
      chk({nm, "_req_stall"}, {31'd0, stall_o}, 32'd1);
      chk({nm, "_addr"}, dmem_addr_o, xaddr);
      chk({nm, "_be"}, {28'd0, dmem_be_o}, {28'd0, xbe});
      chk({nm, "_bubble"}, {26'd0, mem_rd_o, mem_wb_en_o}, 32'd0);
      chk({nm, "_we"}, {31'd0, dmem_we_o}, {31'd0, ~ld});
      if (!ld) chk({nm, "_wdata"}, dmem_wdata_o, xwd);
    end
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    if (ld) begin
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      #1;
      chk({nm, "_wait_stall"}, {31'd0, stall_o}, 32'd1);
      chk({nm, "_wait_req"}, {31'd0, dmem_req_o}, 32'd0);
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    end
    #1;
    chk({nm, "_done_stall"}, {31'd0, stall_o}, 32'd0);
    chk({nm, "_done_wb"}, {31'd0, mem_wb_en_o}, {31'd0, ld});
    chk({nm, "_done_addr"}, dmem_addr_o, xaddr);
    @(negedge clk_i);
    set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk({nm, "_idle_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  initial begin
    // Reset with a load presented: nothing may issue or stall
    set_ex(1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1);
    #12;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_req", {30'd0, dmem_req_o, dmem_we_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    @(negedge clk_i);
    n_rst = 1'b1;
    set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);

    alu(5'd5, 1'b1, 32'h0000_1234, 2'b00);
    alu(5'd6, 1'b1, 32'hA5A5_0001, 2'b11);
    alu(5'd7, 1'b0, 32'h0000_0042, 2'b00);

    mem("lw",  2'b01, 3'b010, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    mem("sb",  2'b10, 3'b000, 32'h103, 32'h12345678, 5'd0, 0, 32'h0, 4'b1000, 32'h78787878, 32'h0);
    mem("sh",  2'b10, 3'b001, 32'h202, 32'hCAFE1234, 5'd0, 0, 32'h0, 4'b1100, 32'h12341234, 32'h0);
    mem("lh",  2'b01, 3'b001, 32'h102, 32'h0, 5'd8, 0, 32'h80FF0000, 4'b1100, 32'h0, 32'hFFFF80FF);
    mem("lhu", 2'b01, 3'b101, 32'h102, 32'h0, 5'd9, 0, 32'h80FF0000, 4'b1100, 32'h0, 32'h000080FF);
    mem("lb",  2'b01, 3'b000, 32'h103, 32'h0, 5'd10, 0, 32'h80FF0000, 4'b1000, 32'h0, 32'hFFFFFF80);
    mem("lbu", 2'b01, 3'b100, 32'h101, 32'h0, 5'd11, 0, 32'h000080FF, 4'b0010, 32'h0, 32'h00000080);
    mem("lw_bp", 2'b01, 3'b010, 32'h340, 32'h0, 5'd12, 4, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);
    mem("sw_bp", 2'b10, 3'b010, 32'h344, 32'h11223344, 5'd0, 3, 32'h0, 4'b1111, 32'h11223344, 32'h0);

    // Flush in WAIT: stall held until rvalid, no write-back
    @(negedge clk_i); set_ex(1'b1, 2'b01, 3'b010, 32'h400, 32'h0, 5'd13, 1'b1);
    @(negedge clk_i); dmem_gnt_i = 1'b1;
    @(negedge clk_i); dmem_gnt_i = 1'b0; flush_i = 1'b1;
    #1 chk("fw_flush_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i); flush_i = 1'b0;
    #1 chk("fw_hold_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55555555;
    #1 chk("fw_rvalid_stall", {31'd0, stall_o}, 32'd1);
    chk("fw_rvalid_wb", {31'd0, mem_wb_en_o}, 32'd0);
    @(negedge clk_i); dmem_rvalid_i = 1'b0; set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk("fw_idle_stall", {31'd0, stall_o}, 32'd0);
    chk("fw_idle_wb", {31'd0, mem_wb_en_o}, 32'd0);
    alu(5'd14, 1'b1, 32'h0000_7777, 2'b00);

    // Flush in REQ before grant: request dropped, back to IDLE
    @(negedge clk_i); set_ex(1'b1, 2'b10, 3'b010, 32'h500, 32'h99, 5'd0, 1'b0);
    @(negedge clk_i); flush_i = 1'b1;
    #1 chk("fr_req", {31'd0, dmem_req_o}, 32'd1);
    @(negedge clk_i); flush_i = 1'b0; set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk("fr_req_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("fr_stall", {31'd0, stall_o}, 32'd0);

    // Flush in IDLE: memory op does not issue, ALU result is suppressed
    @(negedge clk_i); flush_i = 1'b1; set_ex(1'b1, 2'b01, 3'b010, 32'h600, 32'h0, 5'd15, 1'b1);
    #1 chk("fi_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i); set_ex(1'b1, 2'b00, 3'b010, 32'h1234, 32'h0, 5'd15, 1'b1);
    #1 chk("fi_noreq", {31'd0, dmem_req_o}, 32'd0);
    chk("fi_wb", {31'd0, mem_wb_en_o}, 32'd0);
    chk("fi_value", mem_wb_value_o, 32'd0);
    @(negedge clk_i); flush_i = 1'b0; set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    @(negedge clk_i); set_ex(1'b1, 2'b01, 3'b010, 32'h102, 32'h0, 5'd16, 1'b1);
    #1 chk("mis_trap", {31'd0, misalign_o}, 32'd1);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    chk("mis_wb", {31'd0, mem_wb_en_o}, 32'd0);
    @(negedge clk_i); set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`else
    mem("lw_mis", 2'b01, 3'b010, 32'h102, 32'h0, 5'd16, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);
    chk("mis_tied", {31'd0, misalign_o}, 32'd0);
`endif

    // Reset in WAIT abandons the load
    @(negedge clk_i); set_ex(1'b1, 2'b01, 3'b010, 32'h700, 32'h0, 5'd17, 1'b1);
    @(negedge clk_i); dmem_gnt_i = 1'b1;
    @(negedge clk_i); dmem_gnt_i = 1'b0; n_rst = 1'b0;
    #1 chk("mr_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mr_stall", {31'd0, stall_o}, 32'd0);
    chk("mr_addr", dmem_addr_o, 32'd0);
    @(negedge clk_i); n_rst = 1'b1; set_ex(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12121212;
    #1 chk("mr_post_wb", {31'd0, mem_wb_en_o}, 32'd0);
    @(negedge clk_i); dmem_rvalid_i = 1'b0;
    #1 chk("mr_post_stall", {31'd0, stall_o}, 32'd0);

    repeat (3) @(negedge clk_i);
    #3 chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
